alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_if.sv | 36 +++
 rtl/alu_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request / ALU / writeback bundle for alu_sequencer.
// Ports (signals):
//   req_valid, req_ready, req_op[4:0], req_a, req_b   request handshake
//   alu_a, alu_b, alu_op[4:0], alu_result[2W-1:0]     external ALU
//   wb_valid, wb_ready, wb_data, wb_sel               writeback handshake
//   busy, err                                         status
// master = requester/ALU/consumer environment, slave = the sequencer.
interface alu_seq_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                      req_valid;
  logic                      req_ready;
  logic [4:0]                req_op;
  logic [DATA_WIDTH-1:0]     req_a;
  logic [DATA_WIDTH-1:0]     req_b;
  logic [DATA_WIDTH-1:0]     alu_a;
  logic [DATA_WIDTH-1:0]     alu_b;
  logic [4:0]                alu_op;
  logic [2*DATA_WIDTH-1:0]   alu_result;
  logic                      wb_valid;
  logic                      wb_ready;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic                      wb_sel;
  logic                      busy;
  logic                      err;

  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, wb_ready,
    input  req_ready, alu_a, alu_b, alu_op, wb_valid, wb_data, wb_sel, busy, err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result, wb_ready,
    output req_ready, alu_a, alu_b, alu_op, wb_valid, wb_data, wb_sel, busy, err
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU request, drives operands to an external
// combinational ALU, captures its 2*DATA_WIDTH result and writes it back as
// one word (low half) or two words (low then high half, MUL only).
// Ports:
//   clock  rising-edge clock
//   clear  asynchronous active-low reset
//   bus    alu_seq_if.slave (request, ALU, writeback and status signals)
module alu_sequencer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic         clock,
  input  logic         clear,
  alu_seq_if.slave     bus
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned ZW = 2 * DATA_WIDTH;
  localparam logic [4:0]  OP_MUL = 5'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EXEC  = 3'd2,
    WB_LO = 3'd3,
    WB_HI = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [DW-1:0]   r_alu_a;
  logic [DW-1:0]   r_alu_b;
  logic [4:0]      r_alu_op;
  logic [ZW-1:0]   r_z;
  logic            r_err;
  logic            r_wb_valid;
  logic            r_wb_sel;
  logic [DW-1:0]   r_wb_data;
  logic            r_req_ready;
  logic            r_busy;

  logic            w_accept;
  logic            w_illegal;
  logic            w_capture;
  logic            w_wb_valid_nxt;
  logic            w_wb_sel_nxt;
  logic [DW-1:0]   w_wb_data_nxt;

  // State register
  always_ff @(posedge clock or negedge clear) begin : state_reg
    if (!clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, and next values of the registered outputs
  always_comb begin : next_state_logic
    w_next_state   = r_state;
    w_accept       = 1'b0;
    w_illegal      = 1'b0;
    w_capture      = 1'b0;
    w_wb_valid_nxt = 1'b0;
    w_wb_sel_nxt   = 1'b0;
    w_wb_data_nxt  = '0;

    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_op > OP_MUL) begin
            w_illegal = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_next_state = LOAD;
          end
        end
      end
      LOAD:  w_next_state = EXEC;
      EXEC: begin
        w_capture    = 1'b1;
        w_next_state = WB_LO;
      end
      WB_LO: begin
        if (bus.wb_ready) begin
          w_next_state = (r_alu_op == OP_MUL) ? WB_HI : IDLE;
        end
      end
      WB_HI: begin
        if (bus.wb_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase

    // Writeback word follows the state being entered; on entry to WB_LO the
    // low half comes straight from the ALU since Z is loaded on the same edge.
    case (w_next_state)
      WB_LO: begin
        w_wb_valid_nxt = 1'b1;
        w_wb_data_nxt  = w_capture ? bus.alu_result[DW-1:0] : r_z[DW-1:0];
      end
      WB_HI: begin
        w_wb_valid_nxt = 1'b1;
        w_wb_sel_nxt   = 1'b1;
        w_wb_data_nxt  = r_z[ZW-1:DW];
      end
      default: ;
    endcase
  end

  // Operand latch, result capture and registered outputs
  always_ff @(posedge clock or negedge clear) begin : datapath_regs
    if (!clear) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_z         <= '0;
      r_err       <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_sel    <= 1'b0;
      r_wb_data   <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_a  <= bus.req_a;
        r_alu_b  <= bus.req_b;
        r_alu_op <= bus.req_op;
      end
      if (w_capture) begin
        r_z <= bus.alu_result;
      end
      r_err       <= w_illegal;
      r_wb_valid  <= w_wb_valid_nxt;
      r_wb_sel    <= w_wb_sel_nxt;
      r_wb_data   <= w_wb_data_nxt;
      r_req_ready <= (w_next_state == IDLE);
      r_busy      <= (w_next_state != IDLE);
    end
  end

  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.err       = r_err;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.wb_sel    = r_wb_sel;
  assign bus.wb_data   = r_wb_data;
  assign bus.req_ready = r_req_ready;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer with a behavioural
// ALU and a transaction-level reference of the expected writeback words.
module tb_alu_sequencer;

  localparam int unsigned DW = 32;

  logic clock = 1'b0;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  // Reference copy of the operands the sequencer should be presenting
  logic [DW-1:0] m_alu_a = '0;
  logic [DW-1:0] m_alu_b = '0;
  logic [4:0]    m_alu_op = '0;

  always #5 clock = ~clock;

  alu_seq_if #(.DATA_WIDTH(DW)) bus ();

  alu_sequencer #(.DATA_WIDTH(DW)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  // Behavioural team ALU
  function automatic logic [2*DW-1:0] alu_ref(input logic [4:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      5'd0:    return {32'h0, a | b};
      5'd1:    return {32'h0, a & b};
      5'd2:    return 64'(sa + sb);
      5'd3:    return 64'(sa - sb);
      5'd4:    return {32'h0, a} + {32'h0, b};
      5'd5:    return {32'h0, a} * {32'h0, b};
      default: return 64'h0;
    endcase
  endfunction

  always_comb bus.alu_result = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

  // Issue one legal request and observe every writeback handshake until idle.
  // stall = number of cycles wb_ready is held low once the first word appears.
  task automatic run_txn(input logic [4:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input int stall,
                         output int n_wr, output logic [DW-1:0] d0,
                         output logic [DW-1:0] d1, output logic s0,
                         output logic s1, output int lat, output bit hold_ok,
                         output bit zero_ok, output int gap, output bit tmo);
    int edges;
    int last_hs;
    int st;
    bit seen;
    logic [DW-1:0] hd;
    logic hsel;
    n_wr = 0; d0 = '0; d1 = '0; s0 = 1'b0; s1 = 1'b0; lat = -1;
    hold_ok = 1'b1; zero_ok = 1'b1; gap = -1; tmo = 1'b0;
    st = stall; seen = 1'b0; hd = '0; hsel = 1'b0; last_hs = 0;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    bus.wb_ready = 1'b0;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    if (op <= 5'd5) begin
      m_alu_op = op; m_alu_a = a; m_alu_b = b;
    end
    edges = 1;
    while (bus.busy && edges < 60) begin
      if (bus.wb_valid) begin
        if (lat < 0) lat = edges;
        if (seen && (bus.wb_data !== hd || bus.wb_sel !== hsel)) hold_ok = 1'b0;
        if (st > 0) begin
          hd = bus.wb_data; hsel = bus.wb_sel; seen = 1'b1;
          st--;
          bus.wb_ready = 1'b0;
        end else begin
          seen = 1'b0;
          bus.wb_ready = 1'b1;
          if (n_wr == 0) begin d0 = bus.wb_data; s0 = bus.wb_sel; end
          else begin d1 = bus.wb_data; s1 = bus.wb_sel; end
          n_wr++;
          last_hs = edges;
        end
      end else begin
        if (seen) hold_ok = 1'b0;
        if (bus.wb_data !== '0 || bus.wb_sel !== 1'b0) zero_ok = 1'b0;
        bus.wb_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clock); #1;
      edges++;
    end
    bus.wb_ready = 1'b0;
    if (bus.busy) tmo = 1'b1;
    else gap = edges - last_hs;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.wb_ready = 1'b0;
    #1 clear = 1'b0;
    #10;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.wb_valid !== 1'b0 || bus.wb_sel !== 1'b0 || bus.wb_data !== '0) begin errors++; $display("FAIL reset_wb: got valid=%b sel=%b data=%h expected 0/0/0", bus.wb_valid, bus.wb_sel, bus.wb_data); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    checks++; if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_op !== '0) begin errors++; $display("FAIL reset_alu: got a=%h b=%h op=%0d expected 0", bus.alu_a, bus.alu_b, bus.alu_op); end
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_add();
    int n; logic [DW-1:0] d0, d1; logic s0, s1; int lat, gap; bit hok, zok, tmo;
    run_txn(5'd2, 32'd5, 32'd7, 0, n, d0, d1, s0, s1, lat, hok, zok, gap, tmo);
    checks++; if (tmo || n != 1) begin errors++; $display("FAIL add_writes: got %0d (timeout=%0b) expected 1", n, tmo); end
    checks++; if (d0 !== 32'd12 || s0 !== 1'b0) begin errors++; $display("FAIL add_data: got %h sel=%b expected 0000000c sel=0", d0, s0); end
    checks++; if (lat != 3) begin errors++; $display("FAIL add_latency: got %0d expected 3", lat); end
    checks++; if (gap != 1 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL add_ready_after: got gap=%0d ready=%b expected 1/1", gap, bus.req_ready); end
    checks++; if (!zok) begin errors++; $display("FAIL add_idle_zero: got nonzero wb_data/wb_sel with wb_valid low expected 0"); end
  endtask

  task automatic test_mul();
    int n; logic [DW-1:0] d0, d1; logic s0, s1; int lat, gap; bit hok, zok, tmo;
    run_txn(5'd5, 32'h0001_0000, 32'h0001_0000, 0, n, d0, d1, s0, s1, lat, hok, zok, gap, tmo);
    checks++; if (tmo || n != 2) begin errors++; $display("FAIL mul_writes: got %0d (timeout=%0b) expected 2", n, tmo); end
    checks++; if (d0 !== 32'h0 || s0 !== 1'b0) begin errors++; $display("FAIL mul_lo: got %h sel=%b expected 00000000 sel=0", d0, s0); end
    checks++; if (d1 !== 32'h1 || s1 !== 1'b1) begin errors++; $display("FAIL mul_hi: got %h sel=%b expected 00000001 sel=1", d1, s1); end
  endtask

  task automatic test_backpressure();
    int n; logic [DW-1:0] d0, d1; logic s0, s1; int lat, gap; bit hok, zok, tmo;
    run_txn(5'd3, 32'd9, 32'd4, 4, n, d0, d1, s0, s1, lat, hok, zok, gap, tmo);
    checks++; if (!hok) begin errors++; $display("FAIL bp_hold: got wb_data/wb_sel/wb_valid changing under stall expected stable"); end
    checks++; if (tmo || n != 1 || d0 !== 32'd5) begin errors++; $display("FAIL bp_write: got n=%0d data=%h expected n=1 data=00000005", n, d0); end
    checks++; if (lat != 3 || gap != 1) begin errors++; $display("FAIL bp_timing: got lat=%0d gap=%0d expected 3/1", lat, gap); end
  endtask

  task automatic test_illegal(input logic [4:0] op);
    bus.req_valid = 1'b1; bus.req_op = op;
    bus.req_a = $urandom; bus.req_b = $urandom;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL illegal_err_pulse: op=%0d got %b expected 1", op, bus.err); end
    checks++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL illegal_state: got ready=%b busy=%b wb_valid=%b expected 1/0/0", bus.req_ready, bus.busy, bus.wb_valid); end
    checks++; if (bus.alu_op !== m_alu_op || bus.alu_a !== m_alu_a || bus.alu_b !== m_alu_b) begin errors++; $display("FAIL illegal_alu_hold: got op=%0d a=%h expected op=%0d a=%h", bus.alu_op, bus.alu_a, m_alu_op, m_alu_a); end
    @(posedge clock); #1;
    checks++; if (bus.err !== 1'b0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL illegal_err_width: got err=%b wb_valid=%b expected 0/0", bus.err, bus.wb_valid); end
  endtask

  task automatic test_clear_in_wb_hi();
    bit found; bit late_wb;
    int n; logic [DW-1:0] d0, d1; logic s0, s1; int lat, gap; bit hok, zok, tmo;
    found = 1'b0; late_wb = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = 5'd5;
    bus.req_a = 32'h0001_0000; bus.req_b = 32'h0003_0000;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    m_alu_op = 5'd5; m_alu_a = 32'h0001_0000; m_alu_b = 32'h0003_0000;
    bus.wb_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (bus.wb_valid && bus.wb_sel) begin found = 1'b1; break; end
      @(posedge clock); #1;
    end
    bus.wb_ready = 1'b0;
    checks++; if (!found) begin errors++; $display("FAIL clr_reach_wb_hi: got no WB_HI word expected one"); end
    #2 clear = 1'b0;
    m_alu_op = '0; m_alu_a = '0; m_alu_b = '0;
    #1;
    checks++; if (bus.wb_valid !== 1'b0 || bus.wb_data !== '0 || bus.wb_sel !== 1'b0) begin errors++; $display("FAIL clr_wb: got valid=%b data=%h sel=%b expected 0/0/0", bus.wb_valid, bus.wb_data, bus.wb_sel); end
    checks++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL clr_status: got busy=%b ready=%b err=%b expected 0/1/0", bus.busy, bus.req_ready, bus.err); end
    checks++; if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_op !== '0) begin errors++; $display("FAIL clr_alu: got a=%h b=%h op=%0d expected 0", bus.alu_a, bus.alu_b, bus.alu_op); end
    @(posedge clock); #1;
    clear = 1'b1;
    bus.wb_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (bus.wb_valid) late_wb = 1'b1;
      @(posedge clock); #1;
    end
    bus.wb_ready = 1'b0;
    checks++; if (late_wb) begin errors++; $display("FAIL clr_no_reissue: got wb_valid after reset expected none"); end
    run_txn(5'd2, 32'd1, 32'd1, 0, n, d0, d1, s0, s1, lat, hok, zok, gap, tmo);
    checks++; if (tmo || n != 1 || d0 !== 32'd2) begin errors++; $display("FAIL clr_then_add: got n=%0d data=%h expected n=1 data=00000002", n, d0); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] first_d, second_d;
    int k;
    first_d = 'x; second_d = 'x;
    bus.req_valid = 1'b1; bus.req_op = 5'd2; bus.req_a = 32'd3; bus.req_b = 32'd4;
    bus.wb_ready = 1'b1;
    @(posedge clock); #1;
    m_alu_op = 5'd2; m_alu_a = 32'd3; m_alu_b = 32'd4;
    bus.req_a = 32'd100; bus.req_b = 32'd200;
    @(posedge clock); #1;
    checks++; if (bus.req_ready !== 1'b0 || bus.alu_a !== 32'd3) begin errors++; $display("FAIL b2b_exec_ignore: got ready=%b alu_a=%h expected 0/00000003", bus.req_ready, bus.alu_a); end
    k = 0;
    while (!bus.req_ready && k < 10) begin
      if (bus.wb_valid) first_d = bus.wb_data;
      @(posedge clock); #1;
      k++;
    end
    checks++; if (bus.req_ready !== 1'b1 || bus.alu_a !== 32'd3 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_return: got ready=%b alu_a=%h busy=%b expected 1/00000003/0", bus.req_ready, bus.alu_a, bus.busy); end
    checks++; if (first_d !== 32'd7) begin errors++; $display("FAIL b2b_first_data: got %h expected 00000007", first_d); end
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    m_alu_a = 32'd100; m_alu_b = 32'd200;
    checks++; if (bus.alu_a !== 32'd100 || bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got alu_a=%h busy=%b expected 00000064/1", bus.alu_a, bus.busy); end
    k = 0;
    while (bus.busy && k < 20) begin
      if (bus.wb_valid) second_d = bus.wb_data;
      @(posedge clock); #1;
      k++;
    end
    bus.wb_ready = 1'b0;
    checks++; if (bus.busy !== 1'b0 || second_d !== 32'd300) begin errors++; $display("FAIL b2b_second_data: got %h busy=%b expected 0000012c/0", second_d, bus.busy); end
  endtask

  task automatic test_random();
    int n; logic [DW-1:0] d0, d1; logic s0, s1; int lat, gap; bit hok, zok, tmo;
    logic [4:0] op; logic [DW-1:0] a, b; logic [2*DW-1:0] z; int n_exp;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        op = 5'($urandom_range(6, 31));
        test_illegal(op);
      end else begin
        op = 5'($urandom_range(0, 5));
        a = $urandom; b = $urandom;
        z = alu_ref(op, a, b);
        n_exp = (op == 5'd5) ? 2 : 1;
        run_txn(op, a, b, $urandom_range(0, 3), n, d0, d1, s0, s1, lat, hok, zok, gap, tmo);
        checks++; if (tmo || n != n_exp) begin errors++; $display("FAIL rnd_writes: op=%0d got %0d expected %0d", op, n, n_exp); end
        checks++; if (d0 !== z[DW-1:0] || s0 !== 1'b0) begin errors++; $display("FAIL rnd_lo: op=%0d got %h sel=%b expected %h sel=0", op, d0, s0, z[DW-1:0]); end
        if (op == 5'd5) begin
          checks++; if (d1 !== z[2*DW-1:DW] || s1 !== 1'b1) begin errors++; $display("FAIL rnd_hi: got %h sel=%b expected %h sel=1", d1, s1, z[2*DW-1:DW]); end
        end
        checks++; if (lat != 3 || gap != 1 || !hok || !zok) begin errors++; $display("FAIL rnd_protocol: op=%0d got lat=%0d gap=%0d hold=%0b zero=%0b expected 3/1/1/1", op, lat, gap, hok, zok); end
        checks++; if (bus.alu_op !== m_alu_op || bus.alu_a !== m_alu_a || bus.alu_b !== m_alu_b) begin errors++; $display("FAIL rnd_alu_regs: got op=%0d a=%h b=%h expected op=%0d a=%h b=%h", bus.alu_op, bus.alu_a, bus.alu_b, m_alu_op, m_alu_a, m_alu_b); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_backpressure();
    test_illegal(5'd7);
    test_clear_in_wb_hi();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
